// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and ALU command encodings for the ID/EX pipeline register.
// The EX_* values mirror the project's constants.h so both sides agree.
package id_ex_stage_reg_pkg;

    localparam logic [3:0] EX_NOP = 4'b0000;
    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_MVN = 4'b1001;
    localparam logic [3:0] EX_CMP = 4'b0100;
    localparam logic [3:0] EX_TST = 4'b0110;
    localparam logic [3:0] EX_LDR = 4'b0010;
    localparam logic [3:0] EX_STR = 4'b0010;

    typedef struct packed {
        logic       wbEn;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       srUpdate;
        logic [3:0] exCmd;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] valRn;
        logic [31:0] valRm;
        logic        imm;
        logic [11:0] shiftOperand;
        logic [23:0] signedImm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        carry;
    } data_t;

    // A bubble must have no side effect downstream, so every control bit is zero.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter
    import id_ex_stage_reg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble/squash/freeze handling and
// saturating counters for issued and bubbled slots.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             hazard,
    input  logic             WB_en_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             B_in,
    input  logic             S_in,
    input  logic [3:0]       EX_command_in,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      val_Rn_in,
    input  logic [31:0]      val_Rm_in,
    input  logic             imm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm_24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic             carry_in,
    output logic             WB_en_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             B_out,
    output logic             S_out,
    output logic [3:0]       EX_command_out,
    output logic [31:0]      PC_out,
    output logic [31:0]      val_Rn_out,
    output logic [31:0]      val_Rm_out,
    output logic             imm_out,
    output logic [11:0]      shift_operand_out,
    output logic [23:0]      signed_imm_24_out,
    output logic [3:0]       dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic             carry_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t ctrlIn;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    data_t data_d;
    data_t data_q;
    logic  valid_d;
    logic  valid_q;
    logic  squash;

    assign squash = flush | hazard;
    assign ctrlIn = '{wbEn: WB_en_in, memRead: mem_read_in, memWrite: mem_write_in,
                      branch: B_in, srUpdate: S_in, exCmd: EX_command_in};
    assign data_d = '{pc: PC_in, valRn: val_Rn_in, valRm: val_Rm_in, imm: imm_in,
                      shiftOperand: shift_operand_in, signedImm24: signed_imm_24_in,
                      dest: dest_in, src1: src1_in, src2: src2_in, carry: carry_in};

    // Squash and bubble both replace the control word; data fields still load.
    always_comb begin
        ctrl_d  = ctrlIn;
        valid_d = 1'b1;
        if (squash) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_issuedCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (!freeze && !squash),
        .count (issued_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubbleCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (!freeze && squash),
        .count (bubble_cnt)
    );

    assign WB_en_out         = ctrl_q.wbEn;
    assign mem_read_out      = ctrl_q.memRead;
    assign mem_write_out     = ctrl_q.memWrite;
    assign B_out             = ctrl_q.branch;
    assign S_out             = ctrl_q.srUpdate;
    assign EX_command_out    = ctrl_q.exCmd;
    assign PC_out            = data_q.pc;
    assign val_Rn_out        = data_q.valRn;
    assign val_Rm_out        = data_q.valRm;
    assign imm_out           = data_q.imm;
    assign shift_operand_out = data_q.shiftOperand;
    assign signed_imm_24_out = data_q.signedImm24;
    assign dest_out          = data_q.dest;
    assign src1_out          = data_q.src1;
    assign src2_out          = data_q.src2;
    assign carry_out         = data_q.carry;
    assign valid_out         = valid_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg, built with CNT_W=4 so
// counter saturation is reachable in a few cycles.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, flush, freeze, hazard;
    logic WB_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in, carry_in;
    logic [3:0]  EX_command_in, dest_in, src1_in, src2_in;
    logic [31:0] PC_in, val_Rn_in, val_Rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;

    logic WB_en_out, mem_read_out, mem_write_out, B_out, S_out, imm_out, carry_out, valid_out;
    logic [3:0]  EX_command_out, dest_out, src1_out, src2_out;
    logic [31:0] PC_out, val_Rn_out, val_Rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [CW-1:0] issued_cnt, bubble_cnt;

    int checkCount = 0;
    int errorCount = 0;

    id_ex_stage_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
        .WB_en_in(WB_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .B_in(B_in), .S_in(S_in), .EX_command_in(EX_command_in),
        .PC_in(PC_in), .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
        .WB_en_out(WB_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .B_out(B_out), .S_out(S_out), .EX_command_out(EX_command_out),
        .PC_out(PC_out), .val_Rn_out(val_Rn_out), .val_Rm_out(val_Rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
        .valid_out(valid_out), .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setCtrl(input logic wb, input logic mr, input logic mw,
                           input logic b, input logic s, input logic [3:0] cmd);
        WB_en_in = wb; mem_read_in = mr; mem_write_in = mw;
        B_in = b; S_in = s; EX_command_in = cmd;
    endtask

    // Clock one edge, then sample 1 time unit later and check the bubble invariant.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (valid_out == 1'b0) begin
            checkOutput("invariant_ctrl_zero",
                        {23'd0, WB_en_out, mem_read_out, mem_write_out, B_out, S_out, EX_command_out},
                        32'd0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"},  {31'd0, valid_out}, 32'd0);
        checkOutput({tag, "_ctrl"},
                    {23'd0, WB_en_out, mem_read_out, mem_write_out, B_out, S_out, EX_command_out}, 32'd0);
        checkOutput({tag, "_pc"},     PC_out, 32'd0);
        checkOutput({tag, "_rn"},     val_Rn_out, 32'd0);
        checkOutput({tag, "_rm"},     val_Rm_out, 32'd0);
        checkOutput({tag, "_fields"}, {imm_out, shift_operand_out, dest_out, src1_out, src2_out, carry_out}, 32'd0);
        checkOutput({tag, "_simm"},   {8'd0, signed_imm_24_out}, 32'd0);
        checkOutput({tag, "_issued"}, {28'd0, issued_cnt}, 32'd0);
        checkOutput({tag, "_bubble"}, {28'd0, bubble_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; hazard = 1'b0;
        setCtrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
        PC_in = 32'hFFFF_FFFF; val_Rn_in = 32'h1111_1111; val_Rm_in = 32'h2222_2222;
        imm_in = 1'b1; shift_operand_in = 12'hFFF; signed_imm_24_in = 24'hFFFFFF;
        dest_in = 4'hF; src1_in = 4'hF; src2_in = 4'hF; carry_in = 1'b1;
        #2;
        applyStimulus();
        checkAllZero("reset");

        // Load an ADD with every field distinct.
        rst = 1'b0;
        setCtrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EX_ADD);
        PC_in = 32'h0000_0040; val_Rn_in = 32'hDEAD_BEEF; val_Rm_in = 32'h1234_5678;
        imm_in = 1'b1; shift_operand_in = 12'hABC; signed_imm_24_in = 24'h123456;
        dest_in = 4'd7; src1_in = 4'd3; src2_in = 4'd5; carry_in = 1'b1;
        applyStimulus();
        checkOutput("add_valid",  {31'd0, valid_out}, 32'd1);
        checkOutput("add_wb",     {31'd0, WB_en_out}, 32'd1);
        checkOutput("add_cmd",    {28'd0, EX_command_out}, {28'd0, EX_ADD});
        checkOutput("add_issued", {28'd0, issued_cnt}, 32'd1);
        checkOutput("add_bubble", {28'd0, bubble_cnt}, 32'd0);
        checkOutput("pass_pc",    PC_out, 32'h0000_0040);
        checkOutput("pass_rn",    val_Rn_out, 32'hDEAD_BEEF);
        checkOutput("pass_rm",    val_Rm_out, 32'h1234_5678);
        checkOutput("pass_shift", {20'd0, shift_operand_out}, 32'h0000_0ABC);
        checkOutput("pass_dest",  {28'd0, dest_out}, 32'd7);
        checkOutput("pass_src",   {24'd0, src1_out, src2_out}, 32'h0000_0035);
        checkOutput("pass_simm",  {8'd0, signed_imm_24_out}, 32'h0012_3456);
        checkOutput("pass_bits",  {30'd0, imm_out, carry_out}, 32'd3);

        // Load-use hazard while an STR is presented.
        setCtrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EX_STR);
        PC_in = 32'h0000_0044;
        hazard = 1'b1;
        applyStimulus();
        checkOutput("hz_memw",   {31'd0, mem_write_out}, 32'd0);
        checkOutput("hz_valid",  {31'd0, valid_out}, 32'd0);
        checkOutput("hz_cmd",    {28'd0, EX_command_out}, 32'd0);
        checkOutput("hz_bubble", {28'd0, bubble_cnt}, 32'd1);
        checkOutput("hz_issued", {28'd0, issued_cnt}, 32'd1);

        hazard = 1'b0;
        applyStimulus();
        checkOutput("str_memw",   {31'd0, mem_write_out}, 32'd1);
        checkOutput("str_valid",  {31'd0, valid_out}, 32'd1);
        checkOutput("str_cmd",    {28'd0, EX_command_out}, {28'd0, EX_STR});
        checkOutput("str_issued", {28'd0, issued_cnt}, 32'd2);

        // Freeze dominates flush: nothing moves for three cycles.
        freeze = 1'b1; flush = 1'b1;
        setCtrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, EX_MOV);
        PC_in = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("frz_memw",   {31'd0, mem_write_out}, 32'd1);
            checkOutput("frz_valid",  {31'd0, valid_out}, 32'd1);
            checkOutput("frz_b",      {31'd0, B_out}, 32'd0);
            checkOutput("frz_pc",     PC_out, 32'h0000_0044);
            checkOutput("frz_issued", {28'd0, issued_cnt}, 32'd2);
            checkOutput("frz_bubble", {28'd0, bubble_cnt}, 32'd1);
        end

        // Freeze released with flush still high squashes on that edge.
        freeze = 1'b0;
        applyStimulus();
        checkOutput("fl_valid",  {31'd0, valid_out}, 32'd0);
        checkOutput("fl_ctrl",
                    {23'd0, WB_en_out, mem_read_out, mem_write_out, B_out, S_out, EX_command_out}, 32'd0);
        checkOutput("fl_bubble", {28'd0, bubble_cnt}, 32'd2);
        checkOutput("fl_issued", {28'd0, issued_cnt}, 32'd2);
        checkOutput("fl_pc",     PC_out, 32'h0000_0100);

        // Remaining control bits pass through on a plain load.
        flush = 1'b0;
        setCtrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, EX_MOV);
        applyStimulus();
        checkOutput("mov_ctrl",
                    {23'd0, WB_en_out, mem_read_out, mem_write_out, B_out, S_out, EX_command_out},
                    {23'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, EX_MOV});
        checkOutput("mov_issued", {28'd0, issued_cnt}, 32'd3);

        // Everything asserted at once: reset wins.
        rst = 1'b1; freeze = 1'b1; flush = 1'b1; hazard = 1'b1;
        applyStimulus();
        checkAllZero("allhi");

        // Issued counter saturates at 15 with CNT_W=4.
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
        setCtrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EX_ADD);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus();
            checkOutput("sat_issued", {28'd0, issued_cnt}, (i > 15) ? 32'd15 : 32'(i));
        end
        checkOutput("sat_bubble0", {28'd0, bubble_cnt}, 32'd0);

        // Bubble counter saturates too, and issued stays pinned.
        hazard = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus();
        end
        checkOutput("sat_bubble", {28'd0, bubble_cnt}, 32'd15);
        checkOutput("sat_issued_hold", {28'd0, issued_cnt}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
